count_checker: RTL

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker_if.sv | 27 ++
 rtl/count_checker.sv | 122 ++++++++++++
 2 files changed

// File: rtl/count_checker_if.sv
// Bundle of the monitored-counter inputs and the checker's status outputs.
// The master side drives the counter view; the slave side is the checker.
interface count_checker_if #(
    parameter int WIDTH  = 8,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic              cnt_rst;
    logic [WIDTH-1:0]  count;
    logic              clr;
    logic              locked;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [WIDTH-1:0]  bad_expected;
    logic [WIDTH-1:0]  bad_actual;

    modport master (
        output cnt_rst, count, clr,
        input  locked, err, err_cnt, wrap_cnt, bad_expected, bad_actual
    );

    modport slave (
        input  cnt_rst, count, clr,
        output locked, err, err_cnt, wrap_cnt, bad_expected, bad_actual
    );
endinterface

// File: rtl/count_checker.sv
// Watches a free-running counter, counting sequence mismatches and all-ones->0 wraps.
// Define COUNT_CHECKER_STICKY_ERR_EN to make a mismatch latch the ERROR state until clr/reset.
module count_checker #(
    parameter int WIDTH  = 8,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
) (
    input  logic            clock,
    input  logic            reset,
    count_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t            state_reg,        state_next;
    logic [WIDTH-1:0]  prev_count_reg,   prev_count_next;
    logic              prev_rst_reg,     prev_rst_next;
    logic [ERR_W-1:0]  err_cnt_reg,      err_cnt_next;
    logic [WRAP_W-1:0] wrap_cnt_reg,     wrap_cnt_next;
    logic [WIDTH-1:0]  bad_expected_reg, bad_expected_next;
    logic [WIDTH-1:0]  bad_actual_reg,   bad_actual_next;
    logic              err_reg,          err_next;

    logic [WIDTH-1:0]  expected;
    logic              mismatch;
    logic              wrap;

    // A counter just released from its own reset restarts at 0, so that is not a wrap.
    assign expected = prev_rst_reg ? '0 : prev_count_reg + WIDTH'(1);
    assign mismatch = (bus.count != expected);
    assign wrap     = !prev_rst_reg && (prev_count_reg == '1) && (bus.count == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            prev_count_reg   <= '0;
            prev_rst_reg     <= 1'b0;
            err_cnt_reg      <= '0;
            wrap_cnt_reg     <= '0;
            bad_expected_reg <= '0;
            bad_actual_reg   <= '0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            prev_count_reg   <= prev_count_next;
            prev_rst_reg     <= prev_rst_next;
            err_cnt_reg      <= err_cnt_next;
            wrap_cnt_reg     <= wrap_cnt_next;
            bad_expected_reg <= bad_expected_next;
            bad_actual_reg   <= bad_actual_next;
            err_reg          <= err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        prev_count_next   = bus.count;
        prev_rst_next     = bus.cnt_rst;
        err_cnt_next      = err_cnt_reg;
        wrap_cnt_next     = wrap_cnt_reg;
        bad_expected_next = bad_expected_reg;
        bad_actual_next   = bad_actual_reg;
`ifdef COUNT_CHECKER_STICKY_ERR_EN
        err_next          = err_reg;
`else
        err_next          = 1'b0;
`endif

        if (bus.clr) begin
            state_next        = IDLE;
            prev_count_next   = prev_count_reg;
            prev_rst_next     = prev_rst_reg;
            err_cnt_next      = '0;
            wrap_cnt_next     = '0;
            bad_expected_next = '0;
            bad_actual_next   = '0;
            err_next          = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    state_next = TRACK;
                end
                TRACK: begin
                    if (mismatch) begin
                        err_next = 1'b1;
                        if (err_cnt_reg != '1) begin
                            err_cnt_next = err_cnt_reg + ERR_W'(1);
                        end
                        if (err_cnt_reg == '0) begin
                            bad_expected_next = expected;
                            bad_actual_next   = bus.count;
                        end
`ifdef COUNT_CHECKER_STICKY_ERR_EN
                        state_next = ERROR;
`endif
                    end
                    if (wrap && (wrap_cnt_reg != '1)) begin
                        wrap_cnt_next = wrap_cnt_reg + WRAP_W'(1);
                    end
                end
                ERROR: begin
`ifndef COUNT_CHECKER_STICKY_ERR_EN
                    state_next = IDLE;
`endif
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.locked       = (state_reg == TRACK);
    assign bus.err          = err_reg;
    assign bus.err_cnt      = err_cnt_reg;
    assign bus.wrap_cnt     = wrap_cnt_reg;
    assign bus.bad_expected = bad_expected_reg;
    assign bus.bad_actual   = bad_actual_reg;
endmodule
